// File: rtl/divider_32bit_seq.sv
// Sequential 32-bit restoring divider, one quotient bit per clock.
// Contains the subtractor_32bit trial subtractor and the divider_32bit_seq top.
// Define DIV_SIGNED_EN to add the signed_op port and signed (truncating) division.

module subtractor_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        borrow_o
);

  // 33-bit subtraction; the top bit is the borrow (set when a_i < b_i)
  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

module divider_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] remAcc_q, remAcc_d;
  logic [WIDTH-1:0] quoAcc_q, quoAcc_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divByZero_q, divByZero_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ge;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;

`ifdef DIV_SIGNED_EN
  logic signedOp_q, signedOp_d;
  logic negQuo_q, negQuo_d;
  logic negRem_q, negRem_d;

  // Signed operands are reduced to magnitudes at accept; -2^31 maps onto itself, which is the correct unsigned magnitude
  always_comb begin
    dividendMag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    divisorMag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  end
`else
  assign dividendMag = dividend;
  assign divisorMag  = divisor;
`endif

  // Trial subtraction of the divisor from the low word of the shifted partial remainder
  assign shifted = {remAcc_q, quoAcc_q[WIDTH-1]};

  subtractor_32bit uSub (
    .a_i      (shifted[WIDTH-1:0]),
    .b_i      (divisor_q),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // A set 33rd bit already guarantees shifted >= divisor; the low 32 bits of diff stay exact because the result is below divisor
  assign ge      = shifted[WIDTH] | ~borrow;
  assign remNext = ge ? diff : shifted[WIDTH-1:0];
  assign quoNext = {quoAcc_q[WIDTH-2:0], ge};

  // Next-state and datapath decisions; everything holds unless the state says otherwise
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remAcc_d    = remAcc_q;
    quoAcc_d    = quoAcc_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divByZero_d = divByZero_q;
`ifdef DIV_SIGNED_EN
    signedOp_d  = signedOp_q;
    negQuo_d    = negQuo_q;
    negRem_d    = negRem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d   = divisorMag;
          remAcc_d    = '0;
          quoAcc_d    = dividendMag;
          cnt_d       = '0;
          divByZero_d = 1'b0;
`ifdef DIV_SIGNED_EN
          signedOp_d  = signed_op;
          negQuo_d    = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negRem_d    = signed_op & dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            divByZero_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        remAcc_d = remNext;
        quoAcc_d = quoNext;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef DIV_SIGNED_EN
          if (signedOp_q) begin
            state_d = FIX;
          end else begin
            state_d     = DONE;
            quotient_d  = quoNext;
            remainder_d = remNext;
          end
`else
          state_d     = DONE;
          quotient_d  = quoNext;
          remainder_d = remNext;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        state_d     = DONE;
        quotient_d  = negQuo_q ? -quoAcc_q : quoAcc_q;
        remainder_d = negRem_q ? -remAcc_q : remAcc_q;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that also aborts any running division
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      remAcc_q    <= '0;
      quoAcc_q    <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divByZero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      signedOp_q  <= 1'b0;
      negQuo_q    <= 1'b0;
      negRem_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remAcc_q    <= remAcc_d;
      quoAcc_q    <= quoAcc_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divByZero_q <= divByZero_d;
`ifdef DIV_SIGNED_EN
      signedOp_q  <= signedOp_d;
      negQuo_q    <= negQuo_d;
      negRem_q    <= negRem_d;
`endif
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_divider_32bit_seq.sv
// Scoreboard bench for divider_32bit_seq: directed vectors push expected results,
// a monitor pops and compares on every done pulse. Signed vectors need DIV_SIGNED_EN.

module tb_divider_32bit_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          doneCyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        signedOp = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  divider_32bit_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signedOp),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (divByZero)
  );

  // Free-running clock and an edge counter used to measure latency
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, including when it arrives
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", {31'd0, divByZero}, {31'd0, e.dbz});
        checkOutput("done_cycle", cyc, e.doneCyc);
        checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issues one start pulse and records what the accepted job must produce
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input logic [31:0] q, input logic [31:0] r, input logic dbz, input int lat);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    signedOp = sgn;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.q = q; e.r = r; e.dbz = dbz; e.doneCyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int acc;
    exp_t e;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_dbz", {31'd0, divByZero}, 32'd0);

    $display("[TB] basic unsigned vectors");
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);
    waitIdle();
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    waitIdle();
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0, 32);
    waitIdle();
    applyStimulus(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 32);
    waitIdle();
    applyStimulus(32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0, 32);
    waitIdle();

    $display("[TB] divide by zero");
    applyStimulus(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0);
    waitIdle();

    applyStimulus(32'd1000000, 32'd1000, 1'b0, 32'd1000, 32'd0, 1'b0, 32);
    waitIdle();

    $display("[TB] start ignored while busy");
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);
    repeat (8) @(negedge clk);
    checkOutput("busy_calc", {31'd0, busy}, 32'd1);
    checkOutput("hold_quotient", quotient, 32'd1000);
    checkOutput("dbz_cleared", {31'd0, divByZero}, 32'd0);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    $display("[TB] reset mid-operation");
    applyStimulus(32'd77, 32'd7, 1'b0, 32'd11, 32'd0, 1'b0, 32);
    repeat (14) @(negedge clk);
    void'(sb.pop_back());
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
    applyStimulus(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 32);
    waitIdle();

    $display("[TB] start held high across two jobs");
    @(negedge clk);
    dividend = 32'd20;
    divisor  = 32'd4;
    signedOp = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.q = 32'd5; e.r = 32'd0; e.dbz = 1'b0; e.doneCyc = acc + 32;
    sb.push_back(e);
    e.doneCyc = acc + 66;
    sb.push_back(e);
    while (cyc < acc + 34) @(negedge clk);
    start = 1'b0;
    waitIdle();

`ifdef DIV_SIGNED_EN
    $display("[TB] signed vectors");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    waitIdle();
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    waitIdle();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
    waitIdle();
    applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0);
    waitIdle();
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
    waitIdle();
`endif

    repeat (3) @(negedge clk);
    checkOutput("final_pending", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
